// File: rtl/backward_layer_engine_if.sv
// Request/response bundle of backward_layer_engine: control handshake, the forward-pass
// operands and the gradient results. The parameters must match those of the engine.
interface backward_layer_engine_if #(
    parameter int N_IN  = 2,
    parameter int N_OUT = 1
);
    logic              enable;
    logic              start;
    logic signed [15:0] dA      [N_OUT];
    logic signed [15:0] Z       [N_OUT];
    logic signed [15:0] W       [N_OUT][N_IN];
    logic signed [15:0] a_prev  [N_IN];
    logic              busy;
    logic              done;
    logic signed [15:0] dW      [N_OUT][N_IN];
    logic signed [15:0] db      [N_OUT];
    logic signed [15:0] dA_prev [N_IN];

    modport master (
        output enable, start, dA, Z, W, a_prev,
        input  busy, done, dW, db, dA_prev
    );

    modport slave (
        input  enable, start, dA, Z, W, a_prev,
        output busy, done, dW, db, dA_prev
    );
endinterface

// File: rtl/backward_layer_engine.sv
// Backward pass of one dense ReLU layer (dZ, db, dW, dA_prev) on one time-multiplexed Q8.8 MAC.
// Define SATURATE_EN to clamp fixed-point results to 16 bits; otherwise they wrap.
module backward_layer_engine #(
    parameter int N_IN      = 2,
    parameter int N_OUT     = 1,
    parameter int FRAC_BITS = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    backward_layer_engine_if.slave bus
);
    localparam int DATA_W = 16;
    localparam int PROD_W = 32;
    localparam int ACC_W  = PROD_W + $clog2(N_OUT + 1);
    localparam int IW     = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int JW     = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [IW-1:0] I_LAST = IW'(N_OUT - 1);
    localparam logic [JW-1:0] J_LAST = JW'(N_IN - 1);

    typedef logic signed [DATA_W-1:0] data_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DZ,
        S_DW,
        S_DAP,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_i;
    logic [JW-1:0]   r_j;
    acc_t            r_acc;
    logic            r_busy;
    logic            r_done;

    // Operand snapshot taken in LOAD so later input changes cannot disturb a running pass.
    data_t r_da [N_OUT];
    data_t r_z  [N_OUT];
    data_t r_w  [N_OUT][N_IN];
    data_t r_a  [N_IN];
    data_t r_dz [N_OUT];

    data_t r_dw  [N_OUT][N_IN];
    data_t r_db  [N_OUT];
    data_t r_dap [N_IN];

    data_t                  w_dz_val;
    data_t                  w_op_a;
    data_t                  w_op_b;
    logic signed [PROD_W-1:0] w_prod;
    acc_t                   w_prod_ext;
    acc_t                   w_acc_sum;
    acc_t                   w_fx_in;
    data_t                  w_fx;

    // Arithmetic shift floors toward -inf; the result is then narrowed to 16 bits.
    function automatic data_t fx(input acc_t v);
        acc_t shifted;
        shifted = v >>> FRAC_BITS;
`ifdef SATURATE_EN
        if (shifted > acc_t'(32767)) begin
            return data_t'(16'sh7FFF);
        end else if (shifted < -acc_t'(32768)) begin
            return data_t'(16'sh8000);
        end
`endif
        return shifted[DATA_W-1:0];
    endfunction

    // NOTE: every always_comb output is given a default first so no path can infer a latch.
    always_comb begin
        w_op_b = r_a[r_j];
        if (r_state == S_DAP) begin
            w_op_b = r_w[r_i][r_j];
        end
    end

    assign w_dz_val   = (r_z[r_i] > 0) ? r_da[r_i] : data_t'(0);
    assign w_op_a     = r_dz[r_i];
    assign w_prod     = PROD_W'(w_op_a) * PROD_W'(w_op_b);
    assign w_prod_ext = ACC_W'(w_prod);
    assign w_acc_sum  = ((r_i == '0) ? acc_t'(0) : r_acc) + w_prod_ext;
    assign w_fx_in    = (r_state == S_DAP) ? w_acc_sum : w_prod_ext;
    assign w_fx       = fx(w_fx_in);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_i     <= '0;
            r_j     <= '0;
            r_acc   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            // NOTE: these arrays are small register banks, not RAM, so resetting them is cheap and defined.
            r_da    <= '{default: '0};
            r_z     <= '{default: '0};
            r_w     <= '{default: '{default: '0}};
            r_a     <= '{default: '0};
            r_dz    <= '{default: '0};
            r_dw    <= '{default: '{default: '0}};
            r_db    <= '{default: '0};
            r_dap   <= '{default: '0};
        end else if (bus.enable) begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state <= S_LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_da    <= bus.dA;
                    r_z     <= bus.Z;
                    r_w     <= bus.W;
                    r_a     <= bus.a_prev;
                    r_i     <= '0;
                    r_j     <= '0;
                    r_state <= S_DZ;
                end
                S_DZ: begin
                    r_dz[r_i] <= w_dz_val;
                    r_db[r_i] <= w_dz_val;
                    if (r_i == I_LAST) begin
                        r_i     <= '0;
                        r_state <= S_DW;
                    end else begin
                        r_i <= r_i + 1'b1;
                    end
                end
                S_DW: begin
                    r_dw[r_i][r_j] <= w_fx;
                    if (r_j == J_LAST) begin
                        r_j <= '0;
                        if (r_i == I_LAST) begin
                            r_i     <= '0;
                            r_state <= S_DAP;
                        end else begin
                            r_i <= r_i + 1'b1;
                        end
                    end else begin
                        r_j <= r_j + 1'b1;
                    end
                end
                S_DAP: begin
                    // i runs fastest here so each dA_prev column closes after N_OUT terms.
                    r_acc <= w_acc_sum;
                    if (r_i == I_LAST) begin
                        r_dap[r_j] <= w_fx;
                        r_i        <= '0;
                        if (r_j == J_LAST) begin
                            r_j     <= '0;
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_j <= r_j + 1'b1;
                        end
                    end else begin
                        r_i <= r_i + 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.dW      = r_dw;
    assign bus.db      = r_db;
    assign bus.dA_prev = r_dap;

endmodule

// File: tb/tb_backward_layer_engine.sv
// Directed bench for backward_layer_engine: a vector table on the 2x1 layer plus hand-written
// sequences for stall, abort, start-while-busy and a 3x2 layer with random enable.
module tb_backward_layer_engine;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    backward_layer_engine_if #(.N_IN(2), .N_OUT(1)) bif ();
    backward_layer_engine_if #(.N_IN(3), .N_OUT(2)) bif4 ();

    backward_layer_engine #(.N_IN(2), .N_OUT(1), .FRAC_BITS(8)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    backward_layer_engine #(.N_IN(3), .N_OUT(2), .FRAC_BITS(8)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bif4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] da, z, w0, w1, a0, a1;
        logic [15:0] dw0, dw1, db, dap0, dap1;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_inputs(input vec_t v);
        bif.dA[0]     = v.da;
        bif.Z[0]      = v.z;
        bif.W[0][0]   = v.w0;
        bif.W[0][1]   = v.w1;
        bif.a_prev[0] = v.a0;
        bif.a_prev[1] = v.a1;
    endtask

    task automatic check_outputs(input string tag, input vec_t v);
        check({tag, " dW0"}, bif.dW[0][0], v.dw0);
        check({tag, " dW1"}, bif.dW[0][1], v.dw1);
        check({tag, " db"},  bif.db[0], v.db);
        check({tag, " dAp0"}, bif.dA_prev[0], v.dap0);
        check({tag, " dAp1"}, bif.dA_prev[1], v.dap1);
    endtask

    // Presents start in the current cycle; lat counts clock edges from the accepting edge to done.
    task automatic run_op(input vec_t v, output int lat, output int bcnt);
        apply_inputs(v);
        bif.enable = 1'b1;
        bif.start  = 1'b1;
        lat  = 0;
        bcnt = 0;
        do begin
            step();
            bif.start = 1'b0;
            lat++;
            if (bif.busy && !bif.done) bcnt++;
        end while (!bif.done && lat < 50);
    endtask

    task automatic run4(input bit rnd, output int en_cnt);
        bif4.enable = 1'b1;
        bif4.start  = 1'b1;
        step();
        bif4.start = 1'b0;
        en_cnt = 1;
        for (int k = 0; k < 400 && !bif4.done; k++) begin
            bif4.enable = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            if (bif4.enable) en_cnt++;
        end
    endtask

    task automatic check4(input string tag);
        logic [15:0] e_dw [2][3];
        logic [15:0] e_db [2];
        logic [15:0] e_dap [3];
        e_dw  = '{'{16'h0100, 16'hFE00, 16'h0080}, '{16'h0200, 16'hFC00, 16'h0100}};
        e_db  = '{16'h0100, 16'h0200};
        e_dap = '{16'h0180, 16'h0280, 16'h0300};
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s db%0d", tag, i), bif4.db[i], e_db[i]);
            for (int j = 0; j < 3; j++)
                check($sformatf("%s dW%0d%0d", tag, i, j), bif4.dW[i][j], e_dw[i][j]);
        end
        for (int j = 0; j < 3; j++)
            check($sformatf("%s dAp%0d", tag, j), bif4.dA_prev[j], e_dap[j]);
    endtask

    initial begin
        int lat;
        int bcnt;
        int en_cnt;
        int done_seen;
        vec_t junk;

        n_checks = 0;
        n_errors = 0;

        //            name     dA        Z         W0        W1        a0        a1        dW0       dW1       db        dAp0      dAp1
        vecs[0] = '{"case1",  16'h0100, 16'h0080, 16'h0100, 16'h0200, 16'h0300, 16'hFF00, 16'h0300, 16'hFF00, 16'h0100, 16'h0100, 16'h0200};
        vecs[1] = '{"z_zero", 16'h0100, 16'h0000, 16'h0100, 16'h0200, 16'h0300, 16'hFF00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[2] = '{"z_neg",  16'h0100, 16'hFF80, 16'h0100, 16'h0200, 16'h0300, 16'hFF00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
`ifdef SATURATE_EN
        vecs[3] = '{"ovf_dw", 16'h6400, 16'h0100, 16'h0000, 16'h0000, 16'h0200, 16'h0000, 16'h7FFF, 16'h0000, 16'h6400, 16'h0000, 16'h0000};
        vecs[4] = '{"ovf_dap",16'h6400, 16'h0100, 16'hFE00, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h6400, 16'h8000, 16'h6400};
`else
        vecs[3] = '{"ovf_dw", 16'h6400, 16'h0100, 16'h0000, 16'h0000, 16'h0200, 16'h0000, 16'hC800, 16'h0000, 16'h6400, 16'h0000, 16'h0000};
        vecs[4] = '{"ovf_dap",16'h6400, 16'h0100, 16'hFE00, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h6400, 16'h3800, 16'h6400};
`endif
        vecs[5] = '{"neg_da", 16'hFF00, 16'h0200, 16'hFF00, 16'h0080, 16'h0080, 16'h0100, 16'hFF80, 16'hFF00, 16'hFF00, 16'h0100, 16'hFF80};
        vecs[6] = '{"floor",  16'h0001, 16'h0100, 16'h0080, 16'hFF80, 16'h0080, 16'hFF80, 16'h0000, 16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF};

        bif.enable = 1'b1;
        bif.start  = 1'b0;
        apply_inputs(vecs[0]);
        bif4.enable = 1'b1;
        bif4.start  = 1'b0;
        bif4.dA = '{16'h0100, 16'h0200};
        bif4.Z  = '{16'h0100, 16'h0080};
        bif4.W  = '{'{16'h0100, 16'h0080, 16'hFF00}, '{16'h0040, 16'h0100, 16'h0200}};
        bif4.a_prev = '{16'h0100, 16'hFE00, 16'h0080};

        reset = 1'b1;
        repeat (2) step();
        check("rst busy", 16'(bif.busy), 16'h0);
        check("rst done", 16'(bif.done), 16'h0);
        check_outputs("rst", vecs[1]);
        reset = 1'b0;
        step();

        // start with enable low must be ignored
        bif.enable = 1'b0;
        bif.start  = 1'b1;
        repeat (3) step();
        check("no start when stalled", 16'(bif.busy), 16'h0);
        bif.start  = 1'b0;
        bif.enable = 1'b1;
        step();
        check("still idle", 16'(bif.busy), 16'h0);

        for (int k = 0; k < 7; k++) begin
            run_op(vecs[k], lat, bcnt);
            check({vecs[k].name, " latency"}, 16'(lat), 16'd7);
            check({vecs[k].name, " busy cycles"}, 16'(bcnt), 16'd6);
            check({vecs[k].name, " busy in done"}, 16'(bif.busy), 16'h1);
            check_outputs(vecs[k].name, vecs[k]);
            step();
            check({vecs[k].name, " done pulse"}, 16'(bif.done), 16'h0);
            check({vecs[k].name, " busy drop"}, 16'(bif.busy), 16'h0);
        end

        // abort in the middle of DW
        apply_inputs(vecs[0]);
        bif.start = 1'b1;
        step();
        bif.start = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort busy", 16'(bif.busy), 16'h0);
        check("abort done", 16'(bif.done), 16'h0);
        check_outputs("abort", vecs[1]);
        done_seen = 0;
        repeat (10) begin
            step();
            if (bif.done) done_seen++;
        end
        check("abort no done", 16'(done_seen), 16'h0);
        run_op(vecs[0], lat, bcnt);
        check("post-abort latency", 16'(lat), 16'd7);
        check_outputs("post-abort", vecs[0]);
        step();

        // inputs scrambled after LOAD and start re-pulsed during DAP
        apply_inputs(vecs[0]);
        bif.start = 1'b1;
        step();
        bif.start = 1'b0;
        step();
        junk = vecs[5];
        apply_inputs(junk);
        step();
        step();
        step();
        bif.start = 1'b1;
        step();
        bif.start = 1'b0;
        done_seen = (bif.done) ? 1 : 0;
        repeat (15) begin
            step();
            if (bif.done) done_seen++;
        end
        check("busy start ignored", 16'(done_seen), 16'h1);
        check("idle after single op", 16'(bif.busy), 16'h0);
        check_outputs("busy-start", vecs[0]);

        // 3x2 layer, enable held high then randomly toggled
        run4(1'b0, en_cnt);
        check("n4 steady enabled cycles", 16'(en_cnt), 16'd16);
        check("n4 steady done", 16'(bif4.done), 16'h1);
        check4("n4 steady");
        bif4.enable = 1'b1;
        step();
        run4(1'b1, en_cnt);
        check("n4 random enabled cycles", 16'(en_cnt), 16'd16);
        check("n4 random done", 16'(bif4.done), 16'h1);
        check4("n4 random");
        bif4.enable = 1'b0;
        step();
        step();
        check("done held while stalled", 16'(bif4.done), 16'h1);
        bif4.enable = 1'b1;
        step();
        check("done released", 16'(bif4.done), 16'h0);
        check("n4 idle", 16'(bif4.busy), 16'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
